game_master_fsm_multi: RTL

Parametrised round controller for the torpedo game. It sequences one torpedo against N_TARGETS independent target sprites and allows several shots per round. It tracks which targets have been hit, the shots remaining and a saturating score. It sits between the key input, the sprite units, the collision detector and the end-of-game timer, and all its outputs are registered.

---
 rtl/game_master_pkg.sv | 17 +
 rtl/game_score_counter.sv | 55 +++++
 rtl/game_master_fsm_multi.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/game_master_pkg.sv
// Shared definitions for the torpedo game round controller: state encoding
// and the minimum dwell in END before a new round may start.
package game_master_pkg;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_AIM    = 3'd1,
        ST_SHOOT  = 3'd2,
        ST_RELOAD = 3'd3,
        ST_END    = 3'd4
    } state_e;

    // END holds until the counter reaches this value and the timer is idle.
    localparam int unsigned END_MIN_CYCLES = 2;
    localparam int unsigned END_CNT_W      = 2;

endpackage

// File: rtl/game_score_counter.sv
// Saturating score accumulator.
// Ports: clk/rst_n (async active-low), clear_i (sync clear, wins over en_i),
// en_i (credit hits this cycle), hits_i/mask_i (hits counted where both set),
// score_o (registered, saturates at all-ones).
module game_score_counter #(
    parameter int unsigned N_HITS  = 2,
    parameter int unsigned SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic [N_HITS-1:0]  hits_i,
    input  logic [N_HITS-1:0]  mask_i,
    output logic [SCORE_W-1:0] score_o
);

    localparam int unsigned CNT_W = $clog2(N_HITS + 1);
    localparam int unsigned SUM_W = SCORE_W + CNT_W;

    logic [SCORE_W-1:0] score_q, score_d;
    logic [CNT_W-1:0]   cnt_c;
    logic [SUM_W-1:0]   sum_c;

    // Population count of the masked hit vector.
    always_comb begin
        cnt_c = '0;
        for (int unsigned i = 0; i < N_HITS; i++) begin
            cnt_c = cnt_c + CNT_W'(hits_i[i] & mask_i[i]);
        end
    end

    assign sum_c = SUM_W'(score_q) + SUM_W'(cnt_c);

    // Clear overrides increment; any carry past SCORE_W saturates.
    always_comb begin
        score_d = score_q;
        if (clear_i) begin
            score_d = '0;
        end else if (en_i) begin
            score_d = (|sum_c[SUM_W-1:SCORE_W]) ? '1 : sum_c[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score_o = score_q;

endmodule

// File: rtl/game_master_fsm_multi.sv
// Round controller for the torpedo game: one torpedo, N_TARGETS targets,
// SHOTS_PER_ROUND shots per round, saturating score. All outputs registered.
// Inputs : clk, reset_n (async active-low), key (fire on rising edge),
//          score_clear, sprite_target_within_screen, sprite_torpedo_within_screen,
//          collision, end_of_game_timer_running.
// Outputs: target/torpedo sprite load and enable strobes, end_of_game_timer_start,
//          game_won, hit_mask, shots_left, score.
module game_master_fsm_multi
    import game_master_pkg::*;
#(
    parameter int unsigned N_TARGETS       = 2,
    parameter int unsigned SHOTS_PER_ROUND = 3,
    parameter int unsigned SHOT_W          = 4,
    parameter int unsigned SCORE_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key,
    input  logic                 score_clear,
    input  logic [N_TARGETS-1:0] sprite_target_within_screen,
    input  logic                 sprite_torpedo_within_screen,
    input  logic [N_TARGETS-1:0] collision,
    input  logic                 end_of_game_timer_running,
    output logic [N_TARGETS-1:0] sprite_target_write_xy,
    output logic [N_TARGETS-1:0] sprite_target_write_dxy,
    output logic [N_TARGETS-1:0] sprite_target_enable_update,
    output logic                 sprite_torpedo_write_xy,
    output logic                 sprite_torpedo_write_dxy,
    output logic                 sprite_torpedo_enable_update,
    output logic                 end_of_game_timer_start,
    output logic                 game_won,
    output logic [N_TARGETS-1:0] hit_mask,
    output logic [SHOT_W-1:0]    shots_left,
    output logic [SCORE_W-1:0]   score
);

    state_e                 state_q, state_d;
    logic                   key_prev_q;
    logic [END_CNT_W-1:0]   end_cnt_q, end_cnt_d;
    logic [N_TARGETS-1:0]   hit_mask_q, hit_mask_d;
    logic [SHOT_W-1:0]      shots_q, shots_d;
    logic                   won_q, won_d;
    logic [N_TARGETS-1:0]   tgt_wxy_q, tgt_wxy_d;
    logic [N_TARGETS-1:0]   tgt_wdxy_q, tgt_wdxy_d;
    logic [N_TARGETS-1:0]   tgt_en_q, tgt_en_d;
    logic                   torp_wxy_q, torp_wxy_d;
    logic                   torp_wdxy_q, torp_wdxy_d;
    logic                   torp_en_q, torp_en_d;
    logic                   timer_start_q, timer_start_d;

    logic                   key_rise_c;
    logic [N_TARGETS-1:0]   live_c;
    logic [N_TARGETS-1:0]   new_hits_c;
    logic                   target_lost_c;
    logic                   score_en_c;

    assign key_rise_c    = key & ~key_prev_q;
    assign live_c        = ~hit_mask_q;
    assign new_hits_c    = collision & live_c;
    assign target_lost_c = |(~sprite_target_within_screen & live_c);
    assign score_en_c    = (state_q == ST_SHOOT);

    // Next-state, round bookkeeping and registered-output decisions.
    always_comb begin
        state_d       = state_q;
        end_cnt_d     = end_cnt_q;
        hit_mask_d    = hit_mask_q;
        shots_d       = shots_q;
        won_d         = won_q;
        tgt_wxy_d     = '0;
        tgt_wdxy_d    = '0;
        tgt_en_d      = '0;
        torp_wxy_d    = 1'b0;
        torp_wdxy_d   = 1'b0;
        torp_en_d     = 1'b0;
        timer_start_d = 1'b0;

        case (state_q)
            ST_START: begin
                tgt_wxy_d  = '1;
                tgt_wdxy_d = '1;
                torp_wxy_d = 1'b1;
                hit_mask_d = '0;
                shots_d    = SHOT_W'(SHOTS_PER_ROUND);
                won_d      = 1'b0;
                state_d    = ST_AIM;
            end
            ST_AIM: begin
                tgt_en_d = live_c;
                if (key_rise_c && (shots_q != '0)) begin
                    shots_d     = shots_q - SHOT_W'(1);
                    torp_wdxy_d = 1'b1;
                    state_d     = ST_SHOOT;
                end else if (target_lost_c) begin
                    state_d = ST_END;
                end
            end
            ST_SHOOT: begin
                tgt_en_d  = live_c;
                torp_en_d = 1'b1;
                if (|new_hits_c) begin
                    hit_mask_d = hit_mask_q | new_hits_c;
                    if (&hit_mask_d) begin
                        won_d   = 1'b1;
                        state_d = ST_END;
                    end else begin
                        state_d = ST_RELOAD;
                    end
                end else if (!sprite_torpedo_within_screen) begin
                    state_d = (shots_q == '0) ? ST_END : ST_RELOAD;
                end else if (target_lost_c) begin
                    state_d = ST_END;
                end
            end
            ST_RELOAD: begin
                torp_wxy_d = 1'b1;
                tgt_en_d   = live_c;
                state_d    = ST_AIM;
            end
            ST_END: begin
                if (end_cnt_q != END_CNT_W'(END_MIN_CYCLES)) begin
                    end_cnt_d = end_cnt_q + END_CNT_W'(1);
                end else if (!end_of_game_timer_running) begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        // Entering END from any other state: pulse the timer, restart dwell count.
        if ((state_d == ST_END) && (state_q != ST_END)) begin
            timer_start_d = 1'b1;
            end_cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_START;
            key_prev_q    <= 1'b0;
            end_cnt_q     <= '0;
            hit_mask_q    <= '0;
            shots_q       <= '0;
            won_q         <= 1'b0;
            tgt_wxy_q     <= '0;
            tgt_wdxy_q    <= '0;
            tgt_en_q      <= '0;
            torp_wxy_q    <= 1'b0;
            torp_wdxy_q   <= 1'b0;
            torp_en_q     <= 1'b0;
            timer_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_prev_q    <= key;
            end_cnt_q     <= end_cnt_d;
            hit_mask_q    <= hit_mask_d;
            shots_q       <= shots_d;
            won_q         <= won_d;
            tgt_wxy_q     <= tgt_wxy_d;
            tgt_wdxy_q    <= tgt_wdxy_d;
            tgt_en_q      <= tgt_en_d;
            torp_wxy_q    <= torp_wxy_d;
            torp_wdxy_q   <= torp_wdxy_d;
            torp_en_q     <= torp_en_d;
            timer_start_q <= timer_start_d;
        end
    end

    // Only hits on live targets during a shot are credited.
    game_score_counter #(
        .N_HITS  (N_TARGETS),
        .SCORE_W (SCORE_W)
    ) u_score (
        .clk     (clk),
        .rst_n   (reset_n),
        .clear_i (score_clear),
        .en_i    (score_en_c),
        .hits_i  (collision),
        .mask_i  (live_c),
        .score_o (score)
    );

    assign sprite_target_write_xy       = tgt_wxy_q;
    assign sprite_target_write_dxy      = tgt_wdxy_q;
    assign sprite_target_enable_update  = tgt_en_q;
    assign sprite_torpedo_write_xy      = torp_wxy_q;
    assign sprite_torpedo_write_dxy     = torp_wdxy_q;
    assign sprite_torpedo_enable_update = torp_en_q;
    assign end_of_game_timer_start      = timer_start_q;
    assign game_won                     = won_q;
    assign hit_mask                     = hit_mask_q;
    assign shots_left                   = shots_q;

endmodule
